// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: picks the next PC, drives the IMEM address and
// flush/valid strobes, latches misaligned-redirect errors and counts fetches/stalls.
module fetch_ctrl #(
    parameter int                     PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_PC_VAL = {PC_WIDTH{1'b0}},
    parameter int                     CNT_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PC_WIDTH-1:0]   pc_in,
    input  logic                  stall_in,
    input  logic                  redirect_valid_in,
    input  logic [PC_WIDTH-1:0]   redirect_pc_in,
    input  logic                  halt_in,
    output logic                  pc_sel_out,
    output logic [PC_WIDTH-1:0]   pc_new_out,
    output logic [PC_WIDTH-1:0]   imem_addr_out,
    output logic                  inst_valid_out,
    output logic                  flush_out,
    output logic                  misalign_err_out,
    output logic                  halted_out,
    output logic [CNT_WIDTH-1:0]  fetch_cnt_out,
    output logic [CNT_WIDTH-1:0]  stall_cnt_out
);

    // state    | meaning
    // ---------+-----------------------------------------------------------
    // ST_BOOT  | load RESET_PC_VAL into the PC, nothing valid yet
    // ST_RUN   | normal fetch: halt > misaligned redirect > redirect > stall > pc+4
    // ST_HALT  | PC frozen, no valid fetches; only rst leaves this state
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t state;

    logic                 redirect_misaligned;
    logic                 sel_halt;
    logic                 sel_redirect;
    logic                 sel_stall;
    logic                 fetch_inc;
    logic [PC_WIDTH-1:0]  pc_plus4;

    assign pc_plus4            = pc_in + {{(PC_WIDTH-3){1'b0}}, 3'b100};
    assign redirect_misaligned = redirect_valid_in && (redirect_pc_in[1:0] != 2'b00);

    // Priority decode is only meaningful in RUN and never while reset is held.
    always_comb begin
        sel_halt     = 1'b0;
        sel_redirect = 1'b0;
        sel_stall    = 1'b0;
        if (!rst && state == ST_RUN) begin
            if (halt_in || redirect_misaligned) begin
                sel_halt = 1'b1;
            end else if (redirect_valid_in) begin
                sel_redirect = 1'b1;
            end else if (stall_in) begin
                sel_stall = 1'b1;
            end
        end
    end

    always_comb begin
        pc_sel_out     = 1'b1;
        pc_new_out     = RESET_PC_VAL;
        imem_addr_out  = RESET_PC_VAL;
        inst_valid_out = 1'b0;
        flush_out      = 1'b0;
        halted_out     = 1'b0;
        if (!rst) begin
            unique case (state)
                ST_RUN: begin
                    if (sel_halt) begin
                        pc_new_out    = pc_in;
                        imem_addr_out = pc_in;
                        flush_out     = 1'b1;
                    end else if (sel_redirect) begin
                        pc_new_out    = redirect_pc_in;
                        imem_addr_out = redirect_pc_in;
                        flush_out     = 1'b1;
                    end else if (sel_stall) begin
                        pc_new_out     = pc_in;
                        imem_addr_out  = pc_in;
                        inst_valid_out = 1'b1;
                    end else begin
                        pc_sel_out     = 1'b0;
                        pc_new_out     = pc_in;
                        imem_addr_out  = pc_plus4;
                        inst_valid_out = 1'b1;
                    end
                end
                ST_HALT: begin
                    pc_new_out    = pc_in;
                    imem_addr_out = pc_in;
                    halted_out    = 1'b1;
                end
                default: begin
                    pc_new_out    = RESET_PC_VAL;
                    imem_addr_out = RESET_PC_VAL;
                end
            endcase
        end
    end

    assign fetch_inc = inst_valid_out && !stall_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_BOOT;
            misalign_err_out <= 1'b0;
            fetch_cnt_out    <= '0;
            stall_cnt_out    <= '0;
        end else begin
            unique case (state)
                ST_BOOT: state <= ST_RUN;
                ST_RUN:  if (sel_halt) state <= ST_HALT;
                ST_HALT: state <= ST_HALT;
                default: state <= ST_BOOT;
            endcase
            if (state == ST_RUN && redirect_misaligned && !halt_in) begin
                misalign_err_out <= 1'b1;
            end
            // halt_in plus a misaligned redirect still flags the bad target
            if (state == ST_RUN && redirect_misaligned && halt_in) begin
                misalign_err_out <= 1'b1;
            end
            if (fetch_inc) begin
                fetch_cnt_out <= fetch_cnt_out + CNT_WIDTH'(1);
            end
            if (sel_stall) begin
                stall_cnt_out <= stall_cnt_out + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: reset/boot, stall, increment and wrap,
// redirect priority, halt and misaligned redirect, reset out of HALT.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        stall_in;
    logic        redirect_valid_in;
    logic [31:0] redirect_pc_in;
    logic        halt_in;
    logic        pc_sel_out;
    logic [31:0] pc_new_out;
    logic [31:0] imem_addr_out;
    logic        inst_valid_out;
    logic        flush_out;
    logic        misalign_err_out;
    logic        halted_out;
    logic [31:0] fetch_cnt_out;
    logic [31:0] stall_cnt_out;

    int n_chk  = 0;
    int n_fail = 0;

    fetch_ctrl #(.PC_WIDTH(32), .RESET_PC_VAL(32'h0), .CNT_WIDTH(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .pc_in             (pc_in),
        .stall_in          (stall_in),
        .redirect_valid_in (redirect_valid_in),
        .redirect_pc_in    (redirect_pc_in),
        .halt_in           (halt_in),
        .pc_sel_out        (pc_sel_out),
        .pc_new_out        (pc_new_out),
        .imem_addr_out     (imem_addr_out),
        .inst_valid_out    (inst_valid_out),
        .flush_out         (flush_out),
        .misalign_err_out  (misalign_err_out),
        .halted_out        (halted_out),
        .fetch_cnt_out     (fetch_cnt_out),
        .stall_cnt_out     (stall_cnt_out)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then let the combinational outputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall_in          = 1'b0;
        redirect_valid_in = 1'b0;
        redirect_pc_in    = 32'h0;
        halt_in           = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; pc_in = 32'h40; stall_in = 1'b1; halt_in = 1'b1;
        redirect_valid_in = 1'b1; redirect_pc_in = 32'h102;
        tick();
        #1;
        n_chk++; if (pc_sel_out !== 1'b1) begin n_fail++; $display("FAIL rst_pc_sel: got %b want 1", pc_sel_out); end
        n_chk++; if (pc_new_out !== 32'h0) begin n_fail++; $display("FAIL rst_pc_new: got %h want 0", pc_new_out); end
        n_chk++; if (imem_addr_out !== 32'h0) begin n_fail++; $display("FAIL rst_imem: got %h want 0", imem_addr_out); end
        n_chk++; if (inst_valid_out !== 1'b0 || flush_out !== 1'b0 || halted_out !== 1'b0) begin n_fail++; $display("FAIL rst_flags: got v%b f%b h%b want 000", inst_valid_out, flush_out, halted_out); end
        n_chk++; if (fetch_cnt_out !== 32'h0 || stall_cnt_out !== 32'h0 || misalign_err_out !== 1'b0) begin n_fail++; $display("FAIL rst_regs: got f%0d s%0d e%b want 0 0 0", fetch_cnt_out, stall_cnt_out, misalign_err_out); end
        tick();
    endtask

    // Reset has been sampled; deassert and walk through BOOT into RUN.
    task automatic test_boot();
        rst = 1'b0; pc_in = 32'h0; idle_inputs();
        #1;
        n_chk++; if (inst_valid_out !== 1'b0 || imem_addr_out !== 32'h0 || pc_sel_out !== 1'b1) begin n_fail++; $display("FAIL boot_cycle: got v%b a%h s%b want v0 a0 s1", inst_valid_out, imem_addr_out, pc_sel_out); end
        tick();
        n_chk++; if (inst_valid_out !== 1'b1 || imem_addr_out !== 32'h4 || pc_sel_out !== 1'b0) begin n_fail++; $display("FAIL boot_run: got v%b a%h s%b want v1 a4 s0", inst_valid_out, imem_addr_out, pc_sel_out); end
        tick();
        n_chk++; if (fetch_cnt_out !== 32'd1) begin n_fail++; $display("FAIL boot_fetch_cnt: got %0d want 1", fetch_cnt_out); end
    endtask

    task automatic test_stall();
        pc_in = 32'h10; stall_in = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_chk++; if (pc_sel_out !== 1'b1 || pc_new_out !== 32'h10 || imem_addr_out !== 32'h10) begin n_fail++; $display("FAIL stall_pc[%0d]: got s%b n%h a%h want s1 n10 a10", i, pc_sel_out, pc_new_out, imem_addr_out); end
            n_chk++; if (inst_valid_out !== 1'b1 || flush_out !== 1'b0) begin n_fail++; $display("FAIL stall_flags[%0d]: got v%b f%b want v1 f0", i, inst_valid_out, flush_out); end
            tick();
        end
        n_chk++; if (stall_cnt_out !== 32'd3) begin n_fail++; $display("FAIL stall_cnt: got %0d want 3", stall_cnt_out); end
        n_chk++; if (fetch_cnt_out !== 32'd1) begin n_fail++; $display("FAIL stall_fetch_cnt: got %0d want 1", fetch_cnt_out); end
    endtask

    task automatic test_increment_wrap();
        stall_in = 1'b0; pc_in = 32'h10;
        #1;
        n_chk++; if (imem_addr_out !== 32'h14 || pc_sel_out !== 1'b0) begin n_fail++; $display("FAIL inc: got a%h s%b want a14 s0", imem_addr_out, pc_sel_out); end
        tick();
        pc_in = 32'hFFFF_FFFC;
        #1;
        n_chk++; if (imem_addr_out !== 32'h0 || pc_sel_out !== 1'b0) begin n_fail++; $display("FAIL wrap: got a%h s%b want a0 s0", imem_addr_out, pc_sel_out); end
        tick();
        n_chk++; if (fetch_cnt_out !== 32'd3) begin n_fail++; $display("FAIL inc_fetch_cnt: got %0d want 3", fetch_cnt_out); end
    endtask

    task automatic test_redirect_stall();
        pc_in = 32'h20; stall_in = 1'b1; redirect_valid_in = 1'b1; redirect_pc_in = 32'h100;
        #1;
        n_chk++; if (pc_sel_out !== 1'b1 || pc_new_out !== 32'h100 || imem_addr_out !== 32'h100) begin n_fail++; $display("FAIL redir_pc: got s%b n%h a%h want s1 n100 a100", pc_sel_out, pc_new_out, imem_addr_out); end
        n_chk++; if (flush_out !== 1'b1 || inst_valid_out !== 1'b0) begin n_fail++; $display("FAIL redir_flags: got f%b v%b want f1 v0", flush_out, inst_valid_out); end
        tick();
        n_chk++; if (stall_cnt_out !== 32'd3 || fetch_cnt_out !== 32'd3) begin n_fail++; $display("FAIL redir_cnts: got s%0d f%0d want 3 3", stall_cnt_out, fetch_cnt_out); end
        n_chk++; if (halted_out !== 1'b0 || misalign_err_out !== 1'b0) begin n_fail++; $display("FAIL redir_state: got h%b e%b want 0 0", halted_out, misalign_err_out); end
    endtask

    task automatic test_misaligned();
        idle_inputs(); pc_in = 32'h30; redirect_valid_in = 1'b1; redirect_pc_in = 32'h102;
        #1;
        n_chk++; if (flush_out !== 1'b1 || pc_new_out !== 32'h30 || inst_valid_out !== 1'b0) begin n_fail++; $display("FAIL mis_cycle: got f%b n%h v%b want f1 n30 v0", flush_out, pc_new_out, inst_valid_out); end
        n_chk++; if (misalign_err_out !== 1'b0) begin n_fail++; $display("FAIL mis_early: got %b want 0", misalign_err_out); end
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            n_chk++; if (misalign_err_out !== 1'b1 || halted_out !== 1'b1) begin n_fail++; $display("FAIL mis_sticky[%0d]: got e%b h%b want 1 1", i, misalign_err_out, halted_out); end
            n_chk++; if (pc_sel_out !== 1'b1 || pc_new_out !== 32'h30 || imem_addr_out !== 32'h30 || inst_valid_out !== 1'b0 || flush_out !== 1'b0) begin n_fail++; $display("FAIL mis_hold[%0d]: got s%b n%h a%h v%b f%b want s1 n30 a30 v0 f0", i, pc_sel_out, pc_new_out, imem_addr_out, inst_valid_out, flush_out); end
            stall_in = (i == 1); redirect_valid_in = (i == 2); redirect_pc_in = 32'h200;
            tick();
        end
        n_chk++; if (fetch_cnt_out !== 32'd3 || stall_cnt_out !== 32'd3) begin n_fail++; $display("FAIL mis_cnts: got f%0d s%0d want 3 3", fetch_cnt_out, stall_cnt_out); end
    endtask

    task automatic test_reset_in_halt();
        rst = 1'b1; idle_inputs();
        #1;
        n_chk++; if (halted_out !== 1'b0 || imem_addr_out !== 32'h0 || pc_sel_out !== 1'b1 || inst_valid_out !== 1'b0) begin n_fail++; $display("FAIL rsth_during: got h%b a%h s%b v%b want h0 a0 s1 v0", halted_out, imem_addr_out, pc_sel_out, inst_valid_out); end
        tick();
        rst = 1'b0;
        #1;
        n_chk++; if (misalign_err_out !== 1'b0 || fetch_cnt_out !== 32'h0 || stall_cnt_out !== 32'h0) begin n_fail++; $display("FAIL rsth_regs: got e%b f%0d s%0d want 0 0 0", misalign_err_out, fetch_cnt_out, stall_cnt_out); end
        n_chk++; if (halted_out !== 1'b0 || inst_valid_out !== 1'b0 || imem_addr_out !== 32'h0) begin n_fail++; $display("FAIL rsth_boot: got h%b v%b a%h want 0 0 0", halted_out, inst_valid_out, imem_addr_out); end
        tick();
    endtask

    // Halt beats an aligned redirect and a stall; then reset while in a stall.
    task automatic test_halt_priority();
        pc_in = 32'h50; halt_in = 1'b1; stall_in = 1'b1; redirect_valid_in = 1'b1; redirect_pc_in = 32'h200;
        #1;
        n_chk++; if (pc_sel_out !== 1'b1 || pc_new_out !== 32'h50 || flush_out !== 1'b1 || inst_valid_out !== 1'b0) begin n_fail++; $display("FAIL halt_prio: got s%b n%h f%b v%b want s1 n50 f1 v0", pc_sel_out, pc_new_out, flush_out, inst_valid_out); end
        tick();
        idle_inputs();
        #1;
        n_chk++; if (halted_out !== 1'b1 || misalign_err_out !== 1'b0 || stall_cnt_out !== 32'h0) begin n_fail++; $display("FAIL halt_state: got h%b e%b s%0d want 1 0 0", halted_out, misalign_err_out, stall_cnt_out); end
        rst = 1'b1; tick(); rst = 1'b0; tick();
        pc_in = 32'h60; stall_in = 1'b1;
        tick(); tick();
        n_chk++; if (stall_cnt_out !== 32'd2) begin n_fail++; $display("FAIL stall_cnt2: got %0d want 2", stall_cnt_out); end
        rst = 1'b1;
        tick();
        n_chk++; if (stall_cnt_out !== 32'h0 || pc_new_out !== 32'h0 || inst_valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall: got s%0d n%h v%b want 0 0 0", stall_cnt_out, pc_new_out, inst_valid_out); end
        rst = 1'b0; idle_inputs();
    endtask

    initial begin
        rst = 1'b1; pc_in = 32'h0;
        idle_inputs();
        #1;
        test_reset();
        test_boot();
        test_stall();
        test_increment_wrap();
        test_redirect_stall();
        test_misaligned();
        test_reset_in_halt();
        test_halt_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
